// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: registers operands for a multicycle Booth multiplier and captures its product after a settle window.
// Optional MUL_OVF_FLAG_EN adds a registered ovf flag (product does not fit in signed 32 bits).
module mul_issue_ctrl #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        ack,
   output logic [31:0] mult_out,
   output logic [31:0] multr_out,
   input  logic [31:0] prod_hi_in,
   input  logic [31:0] prod_lo_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] zhigh,
   output logic [31:0] zlow
`ifdef MUL_OVF_FLAG_EN
   ,output logic       ovf
`endif
);
   typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] mult_q, mult_d, multr_q, multr_d, zhigh_q, zhigh_d, zlow_q, zlow_d;
   logic        busy_q, busy_d, done_q, done_d, load, capture;
`ifdef MUL_OVF_FLAG_EN
   logic        ovf_q, ovf_d;
`endif
   always_comb begin
      load    = start && (state_q == IDLE || (state_q == DONE && ack));
      capture = state_q == SETTLE && cnt_q == 4'd0;
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = load ? SETTLE : IDLE;
         SETTLE:  state_d = capture ? DONE : SETTLE;
         DONE:    state_d = ack ? (load ? SETTLE : IDLE) : DONE;
         default: state_d = IDLE;
      endcase
      cnt_d   = load ? 4'(SETTLE_CYCLES - 1) : (state_q == SETTLE && !capture) ? cnt_q - 4'd1 : cnt_q;
      mult_d  = load ? op_a : mult_q;
      multr_d = load ? op_b : multr_q;
      zhigh_d = capture ? prod_hi_in : zhigh_q;
      zlow_d  = capture ? prod_lo_in : zlow_q;
      busy_d  = state_d != IDLE;
      done_d  = state_d == DONE;
   end
`ifdef MUL_OVF_FLAG_EN
   // Overflow when the high word is not a pure sign extension of the low word.
   always_comb ovf_d = capture ? (prod_hi_in != {32{prod_lo_in[31]}}) : ovf_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) ovf_q <= 1'b0;
      else ovf_q <= ovf_d;
   assign ovf = ovf_q;
`endif
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         mult_q  <= 32'd0;
         multr_q <= 32'd0;
         zhigh_q <= 32'd0;
         zlow_q  <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mult_q  <= mult_d;
         multr_q <= multr_d;
         zhigh_q <= zhigh_d;
         zlow_q  <= zlow_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign mult_out  = mult_q;
   assign multr_out = multr_q;
   assign zhigh     = zhigh_q;
   assign zlow      = zlow_q;
   assign busy      = busy_q;
   assign done      = done_q;
endmodule
